// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch stage: sequential fetch over req/gnt/rvalid,
// in-order {pc, instr} FIFO toward decode, redirect flush with discard.
module instr_prefetch_unit #(
  parameter int unsigned    DW       = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [DW-1:0]  RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  input  logic          redirect_i,
  input  logic [DW-1:0] redirect_pc_i,
  input  logic          stall_i,
  output logic          instr_valid_o,
  output logic [DW-1:0] instr_o,
  output logic [DW-1:0] pc_o,
  output logic [DW-1:0] pc_plus_4_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] NOP  = DW'(32'h0000_0013);
  localparam logic [DW-1:0] STEP = DW'(4);
  localparam logic [CW:0]   LIM  = (CW+1)'(DEPTH);

  logic [DW-1:0] r_fetch_pc;
  logic [DW-1:0] r_resp_pc;
  logic [DW-1:0] r_pc_mem  [DEPTH];
  logic [DW-1:0] r_ins_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;

  logic [CW:0]   w_used;
  logic          w_req;
  logic          w_fire;
  logic          w_rsp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [DW-1:0] w_redir_pc;

  // Credit counts in-flight requests too, so the FIFO can never overflow
  assign w_used     = {1'b0, r_occ} + {1'b0, r_out};
  assign w_req      = !rst_i && !redirect_i && (w_used < LIM);
  assign w_fire     = w_req && imem_gnt_i;
  assign w_rsp      = imem_rvalid_i && (r_out != '0);
  assign w_drop     = w_rsp && (r_disc != '0);
  assign w_push     = w_rsp && !w_drop && !redirect_i && !rst_i;
  assign w_valid    = (r_occ != '0) && !rst_i;
  assign w_pop      = w_valid && !stall_i && !redirect_i;
  assign w_redir_pc = redirect_pc_i & ~DW'(3);

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_ins_mem[r_rd_ptr] : NOP;
  assign pc_o          = w_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign pc_plus_4_o   = pc_o + STEP;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_out      <= '0;
      r_disc     <= '0;
    end else if (redirect_i) begin
      // Everything still in flight is wrong-path from here on
      r_fetch_pc <= w_redir_pc;
      r_resp_pc  <= w_redir_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_out      <= r_out - CW'(w_rsp);
      r_disc     <= r_out - CW'(w_rsp);
    end else begin
      if (w_fire)
        r_fetch_pc <= r_fetch_pc + STEP;
      r_out <= r_out + CW'(w_fire) - CW'(w_rsp);
      if (w_drop)
        r_disc <= r_disc - CW'(1);
      if (w_push) begin
        r_resp_pc <= r_resp_pc + STEP;
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_resp_pc;
      r_ins_mem[r_wr_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: in-order memory model with variable
// latency, grant-order scoreboard checked at every decode pop.
module tb_instr_prefetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_4_o;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lat = 1;
  int   grants = 0;
  int   pops = 0;
  logic gnt_en = 1'b1;

  typedef struct {
    logic [31:0] d;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  pend_t       pend[$];
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_fetch = RPC;

  instr_prefetch_unit #(
    .DW(32), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus_4_o(pc_plus_4_o)
  );

  always #5 clk = ~clk;
  assign imem_gnt_i = gnt_en;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory: responses in grant order, lat cycles after grant
  always begin
    @(posedge clk);
    if (rst_i) pend.delete();
    else begin
      if (imem_req_o && imem_gnt_i)
        pend.push_back('{memf(imem_addr_o), cyc + lat});
      if (imem_rvalid_i && pend.size() > 0)
        void'(pend.pop_front());
    end
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pend[0].d;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  // Scoreboard: expected entries pushed at grant, compared at pop
  always @(posedge clk) begin
    if (rst_i) begin
      sb.delete();
      exp_fetch = RPC;
    end else if (redirect_i) begin
      checks++;
      if (imem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL redirect_req: req=%0b required 0", imem_req_o);
      end
      sb.delete();
      exp_fetch = redirect_pc_i & ~32'h3;
    end else begin
      if (instr_valid_o && !stall_i) begin
        pops++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_empty: pc=%h with no entry expected", pc_o);
        end else begin
          mon_e = sb.pop_front();
          if (pc_o !== mon_e.pc || instr_o !== mon_e.ins ||
              pc_plus_4_o !== mon_e.pc + 32'd4) begin
            errors++;
            $display("FAIL pop: pc=%h ins=%h p4=%h required %h %h %h",
                     pc_o, instr_o, pc_plus_4_o,
                     mon_e.pc, mon_e.ins, mon_e.pc + 32'd4);
          end
        end
      end
      if (imem_req_o && imem_gnt_i) begin
        grants++;
        checks++;
        if (imem_addr_o !== exp_fetch || sb.size() >= DEPTH) begin
          errors++;
          $display("FAIL grant: addr=%h used=%0d required %h used<%0d",
                   imem_addr_o, sb.size(), exp_fetch, DEPTH);
        end
        sb.push_back('{exp_fetch, memf(exp_fetch)});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(2);
    checks++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: req=%0b valid=%0b required 0 0",
               imem_req_o, instr_valid_o);
    end
    checks++;
    if (instr_o !== NOP || pc_o !== 32'h0 || pc_plus_4_o !== 32'h4) begin
      errors++;
      $display("FAIL reset_data: ins=%h pc=%h p4=%h required %h 0 4",
               instr_o, pc_o, pc_plus_4_o, NOP);
    end
  endtask

  task automatic test_stream();
    int p0;
    lat = 1;
    rst_i = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RPC) begin
      errors++;
      $display("FAIL first_req: req=%0b addr=%h required 1 %h",
               imem_req_o, imem_addr_o, RPC);
    end
    @(negedge clk);
    checks++;
    if (instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: valid=%0b required 0", instr_valid_o);
    end
    @(negedge clk);
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== RPC) begin
      errors++;
      $display("FAIL latency: valid=%0b pc=%h required 1 %h",
               instr_valid_o, pc_o, RPC);
    end
    p0 = pops;
    tick(10);
    checks++;
    if (pops - p0 != 10) begin
      errors++;
      $display("FAIL throughput: pops=%0d required 10", pops - p0);
    end
  endtask

  task automatic test_stall();
    int g0;
    int p0;
    stall_i = 1'b1;
    do_reset();
    g0 = grants;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_valid_o) begin
        checks++;
        if (pc_o !== RPC) begin
          errors++;
          $display("FAIL stall_head: pc=%h required %h", pc_o, RPC);
        end
      end
    end
    checks++;
    if (grants - g0 != DEPTH || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_credit: grants=%0d req=%0b required %0d 0",
               grants - g0, imem_req_o, DEPTH);
    end
    stall_i = 1'b0;
    p0 = pops;
    g0 = grants;
    tick(4);
    checks++;
    if (pops - p0 != 4 || grants == g0) begin
      errors++;
      $display("FAIL stall_drain: pops=%0d grants=%0d required 4 >0",
               pops - p0, grants - g0);
    end
  endtask

  task automatic test_redirect_inflight();
    bit seen;
    lat = 3;
    do_reset();
    tick(2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 ||
        instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redir_req: req=%0b addr=%h valid=%0b required 1 100 0",
               imem_req_o, imem_addr_o, instr_valid_o);
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = instr_valid_o;
    end
    checks++;
    if (!seen || pc_o !== 32'h100 || instr_o !== memf(32'h100)) begin
      errors++;
      $display("FAIL redir_head: seen=%0b pc=%h ins=%h required 1 100 %h",
               seen, pc_o, instr_o, memf(32'h100));
    end
  endtask

  task automatic test_redirect_same_cycle();
    int p0;
    lat = 1;
    do_reset();
    tick(6);
    checks++;
    if (instr_valid_o !== 1'b1 || imem_rvalid_i !== 1'b1) begin
      errors++;
      $display("FAIL same_pre: valid=%0b rvalid=%0b required 1 1",
               instr_valid_o, imem_rvalid_i);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 32'h0 ||
        pc_plus_4_o !== 32'h4) begin
      errors++;
      $display("FAIL same_flush: valid=%0b ins=%h pc=%h p4=%h required 0",
               instr_valid_o, instr_o, pc_o, pc_plus_4_o);
    end
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL same_req: req=%0b addr=%h required 1 200",
               imem_req_o, imem_addr_o);
    end
    p0 = pops;
    tick(8);
    checks++;
    if (pops - p0 != 6) begin
      errors++;
      $display("FAIL same_resume: pops=%0d required 6", pops - p0);
    end
  endtask

  task automatic test_gnt_hold();
    logic [31:0] a;
    int g0;
    gnt_en = 1'b0;
    #1;
    a = imem_addr_o;
    g0 = grants;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== a) begin
        errors++;
        $display("FAIL gnt_hold: req=%0b addr=%h required 1 %h",
                 imem_req_o, imem_addr_o, a);
      end
    end
    gnt_en = 1'b1;
    @(negedge clk);
    checks++;
    if (grants - g0 != 1 || imem_addr_o !== a + 32'd4) begin
      errors++;
      $display("FAIL gnt_resume: grants=%0d addr=%h required 1 %h",
               grants - g0, imem_addr_o, a + 32'd4);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    checks++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_align: addr=%h required fffffffc", imem_addr_o);
    end
    @(negedge clk);
    checks++;
    if (imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: addr=%h required 0", imem_addr_o);
    end
    seen = instr_valid_o;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = instr_valid_o;
    end
    checks++;
    if (!seen || pc_o !== 32'hFFFF_FFFC || pc_plus_4_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_head: seen=%0b pc=%h p4=%h required 1 fffffffc 0",
               seen, pc_o, pc_plus_4_o);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    tick(3);
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 ||
        instr_o !== NOP || pc_o !== 32'h0 || pc_plus_4_o !== 32'h4) begin
      errors++;
      $display("FAIL mid_reset: req=%0b valid=%0b ins=%h pc=%h p4=%h",
               imem_req_o, instr_valid_o, instr_o, pc_o, pc_plus_4_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RPC) begin
      errors++;
      $display("FAIL mid_restart: req=%0b addr=%h required 1 %h",
               imem_req_o, imem_addr_o, RPC);
    end
    p0 = pops;
    tick(6);
    checks++;
    if (pops - p0 != 4) begin
      errors++;
      $display("FAIL mid_stream: pops=%0d required 4", pops - p0);
    end
  endtask

  task automatic test_random();
    int p0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      stall_i = ($urandom % 4) == 0;
      gnt_en = ($urandom % 3) != 0;
      lat = 1 + int'($urandom % 3);
      redirect_i = ($urandom % 25) == 0;
      redirect_pc_i = $urandom;
    end
    @(negedge clk);
    stall_i = 1'b0;
    gnt_en = 1'b1;
    redirect_i = 1'b0;
    lat = 1;
    tick(6);
    p0 = pops;
    tick(10);
    checks++;
    if (pops - p0 != 10) begin
      errors++;
      $display("FAIL random_settle: pops=%0d required 10", pops - p0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_gnt_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Instruction prefetch stage between the instruction memory port and the fetch/decode pipeline register of the 3-stage core. It issues sequential fetch requests over a request/grant/response memory handshake and buffers returned words with their PCs in a small in-order FIFO. It presents one instruction per cycle to the decode stage, honours decode stalls, and restarts fetch from a new PC on a taken branch or jump redirect, discarding wrong-path data still in flight.

## Interface
Parameters:
- DW, 32, data/address width
- DEPTH, 4, FIFO entries; also the maximum number of requests in flight (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  DW  fetch address (word-aligned)
- imem_gnt_i  in  1  request accepted this cycle when imem_req_o is also high
- imem_rvalid_i  in  1  response valid; responses return in grant order, at least 1 cycle after grant
- imem_rdata_i  in  DW  response instruction word
- redirect_i  in  1  flush and restart fetch (branch taken)
- redirect_pc_i  in  DW  new fetch PC, valid with redirect_i
- stall_i  in  1  decode stage not accepting (stall_fd)
- instr_valid_o  out  1  FIFO head valid
- instr_o  out  DW  head instruction; 32'h0000_0013 (NOP) when empty
- pc_o  out  DW  PC of head instruction; 0 when empty
- pc_plus_4_o  out  DW  pc_o + 4 (modulo 2^DW)

## Operation
- State: fetch_pc (next request address), resp_pc (PC of next kept response), FIFO of {pc, instr} with occupancy count, outstanding counter (0..DEPTH), discard counter (0..DEPTH).
- Request: imem_req_o = !rst_i & !redirect_i & (occupancy + outstanding < DEPTH); imem_addr_o = fetch_pc. On req & gnt: fetch_pc += 4, outstanding += 1.
- Response: on imem_rvalid_i, outstanding -= 1. If discard > 0, word dropped, discard -= 1. Otherwise push {resp_pc, imem_rdata_i}, resp_pc += 4.
- Pop: when instr_valid_o & !stall_i & !redirect_i, head removed.
- Redirect (highest priority): FIFO cleared (occupancy 0, including head), fetch_pc and resp_pc <= redirect_pc_i, discard <= outstanding − imem_rvalid_i (every in-flight request becomes wrong-path; a same-cycle response is dropped), outstanding <= outstanding − imem_rvalid_i. No request issued in the redirect cycle.
- Simultaneous gnt and rvalid: outstanding unchanged. Simultaneous push and pop: occupancy unchanged.
- Credit check uses current-cycle counts only (a same-cycle pop does not free a slot); FIFO can never overflow.
- Outputs combinational from FIFO head.
- Arithmetic: all PC increments wrap modulo 2^DW; redirect_pc_i[1:0] is ignored (forced to 0).

## Timing
- Reset (rst_i high at edge): fetch_pc = resp_pc = RESET_PC, occupancy = outstanding = discard = 0. While rst_i high: imem_req_o = 0, instr_valid_o = 0, instr_o = NOP, pc_o = 0, pc_plus_4_o = 4. Reset mid-operation abandons in-flight responses; memory is reset concurrently.
- Best-case latency: grant at cycle N, rvalid at N+1, instr_valid_o at N+2.
- Redirect at cycle R: first new request at R+1 with imem_addr_o = redirect_pc_i; instr_valid_o low at R+1.
- Steady state with single-cycle memory and no stalls: one instruction per cycle after fill.
- Stall held: head and outputs stable; fetch continues until occupancy + outstanding = DEPTH, then imem_req_o low.

## Test plan
- Reset, RESET_PC=0, gnt always 1, rvalid 1 cycle later -> addresses 0,4,8,… on consecutive cycles; instr_valid_o from cycle 2, pc_o 0,4,8 in order, pc_plus_4_o = pc_o+4.
- stall_i held 10 cycles, DEPTH=4 -> exactly 4 grants, imem_req_o low once occupancy+outstanding=4, head pc_o unchanged; release -> drains 4 entries in order, fetch resumes.
- 2 requests in flight (rvalid delayed 3 cycles), redirect to 0x100 -> both stale responses dropped, next valid pc_o = 0x100 with word from address 0x100.
- Redirect in same cycle as rvalid and non-stalled pop -> response dropped, FIFO empty next cycle, no pop of any later entry, outstanding/discard consistent (no deadlock).
- gnt withheld 5 cycles -> imem_req_o and imem_addr_o held stable; fetch_pc advances only on grant.
- fetch_pc = 0xFFFF_FFFC -> next address 0x0000_0000; rst_i asserted mid-stream -> all outputs at reset values next cycle, fetch restarts at RESET_PC.
